// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package seq_restoring_divider_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_restoring_divider_cla_subtractor.sv
// N-bit subtractor a - b computed as a + ~b + 1 with generate/propagate carry terms.
// Only the low N-1 difference bits are produced: the top bit is always 0 when there is no borrow.
module seq_restoring_divider_cla_subtractor #(
    parameter int N = 5
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-2:0] o_diff,
    output logic         o_no_borrow
);

    logic [N-1:0] w_g;
    logic [N-1:0] w_p;

    assign w_g = i_a & ~i_b;
    assign w_p = i_a ^ ~i_b;

    always_comb begin
        logic c;
        c      = 1'b1;
        o_diff = '0;
        for (int i = 0; i < N; i++) begin
            if (i < N - 1) begin
                o_diff[i] = w_p[i] ^ c;
            end
            c = w_g[i] | (w_p[i] & c);
        end
        o_no_borrow = c;
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Handshake: start is only looked at in IDLE; done is a one-cycle pulse and results hold until the next op.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state,     w_state_n;
    logic [CW-1:0]    r_count,     w_count_n;
    logic [WIDTH-1:0] r_rem,       w_rem_n;
    logic [WIDTH-1:0] r_q,         w_q_n;
    logic [WIDTH-1:0] r_divisor,   w_divisor_n;
    logic [WIDTH-1:0] r_quotient,  w_quotient_n;
    logic [WIDTH-1:0] r_remainder, w_remainder_n;
    logic             r_dbz,       w_dbz_n;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_no_borrow;

    // Partial remainder shifted left with the next dividend bit pulled in from the top of q.
    assign w_shift = {r_rem, r_q[WIDTH-1]};

    seq_restoring_divider_cla_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .i_a         (w_shift),
        .i_b         ({1'b0, r_divisor}),
        .o_diff      (w_diff),
        .o_no_borrow (w_no_borrow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_count     <= w_count_n;
            r_rem       <= w_rem_n;
            r_q         <= w_q_n;
            r_divisor   <= w_divisor_n;
            r_quotient  <= w_quotient_n;
            r_remainder <= w_remainder_n;
            r_dbz       <= w_dbz_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_count_n     = r_count;
        w_rem_n       = r_rem;
        w_q_n         = r_q;
        w_divisor_n   = r_divisor;
        w_quotient_n  = r_quotient;
        w_remainder_n = r_remainder;
        w_dbz_n       = r_dbz;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_divisor_n = divisor;
                    w_rem_n     = '0;
                    w_q_n       = dividend;
                    w_count_n   = '0;
                    w_dbz_n     = 1'b0;
                    if (divisor == '0) begin
                        w_state_n     = ST_DONE;
                        w_quotient_n  = '1;
                        w_remainder_n = dividend;
                        w_dbz_n       = 1'b1;
                    end else begin
                        w_state_n = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Keep the trial difference only when it did not borrow; otherwise restore.
                w_rem_n   = w_no_borrow ? w_diff : w_shift[WIDTH-1:0];
                w_q_n     = {r_q[WIDTH-2:0], w_no_borrow};
                w_count_n = r_count + 1'b1;
                if (r_count == LAST) begin
                    w_state_n     = ST_DONE;
                    w_quotient_n  = w_q_n;
                    w_remainder_n = w_rem_n;
                end
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases, reset abort, start noise, full sweep.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  logic [2*W:0] exp_q[$];
  int           n_checks;
  int           n_bad;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // scoreboard: every done pulse is matched against the oldest expected result
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", 1, 0);
      end else begin
        logic [2*W:0] e;
        e = exp_q.pop_front();
        check_eq("quotient", {28'd0, quotient}, {28'd0, e[2*W-1:W]});
        check_eq("remainder", {28'd0, remainder}, {28'd0, e[W-1:0]});
        check_eq("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[2*W]});
      end
    end
  end

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == 0) return {1'b1, {W{1'b1}}, a};
    q = a / b;
    r = a % b;
    return {1'b0, q, r};
  endfunction

  // driver: call mid-cycle; returns #1 after the edge that ends the done cycle
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    int lat;
    int exp_lat;
    bit seen;
    exp_q.push_back(model(a, b));
    exp_lat  = (b == 0) ? 0 : W;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      check_eq("busy_in_run", {31'd0, busy}, 1);
      if (noise) begin
        start    = 1'b1;
        dividend = W'($urandom_range(0, 15));
        divisor  = W'($urandom_range(0, 15));
      end
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
    if (!seen) begin
      check_eq("done_timeout", 0, 1);
    end else begin
      check_eq("latency", lat, exp_lat);
      check_eq("busy_in_done", {31'd0, busy}, 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_busy"}, {31'd0, busy}, 0);
    check_eq({tag, "_done"}, {31'd0, done}, 0);
    check_eq({tag, "_q"}, {28'd0, quotient}, 0);
    check_eq({tag, "_r"}, {28'd0, remainder}, 0);
    check_eq({tag, "_dbz"}, {31'd0, div_by_zero}, 0);
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    // 13/3 then 7/0 with busy dropping after the divide-by-zero done
    run_op(4'd13, 4'd3, 1'b0);
    run_op(4'd7, 4'd0, 1'b0);
    @(negedge clk);
    check_eq("busy_after_dbz", {31'd0, busy}, 0);

    // boundaries
    run_op(4'd3, 4'd9, 1'b0);
    run_op(4'd15, 4'd1, 1'b0);
    run_op(4'd0, 4'd5, 1'b0);

    // start/operand noise during RUN
    run_op(4'd12, 4'd5, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // reset two cycles into a run aborts it with no done
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_zero("abort");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    run_op(4'd14, 4'd4, 1'b0);

    // back-to-back
    run_op(4'd9, 4'd2, 1'b0);
    run_op(4'd15, 4'd15, 1'b0);

    // full operand sweep, back-to-back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), 1'b0);
      end
    end

    // randomised ops with start noise and random gaps
    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (10) @(posedge clk);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
